// File: rtl/mem_rd_return.sv
// mem_rd_return: load-return unit on the data-memory read path.
//
// Accepts load requests from the memory stage and forwards a word-aligned read
// to data memory in the same cycle. It keeps up to DEPTH outstanding loads in
// order, captures in-order read responses, and presents the head load to
// writeback once its word has arrived. The result is byte/halfword extracted
// and sign/zero extended there.
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid/req_ready               load request handshake
//   req_fnc, req_addr, req_rd         funct3, byte address, destination register
//   mem_req_valid/mem_req_ready       read issue handshake to data memory
//   mem_req_addr                      word-aligned read address
//   mem_rsp_valid, mem_rsp_data       in-order read data, no backpressure
//   wb_valid/wb_ready                 writeback handshake
//   wb_data, wb_rd, wb_err            formatted result, destination, error flag

module mem_rd_return #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RD_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_fnc,
    input  logic [31:0]     req_addr,
    input  logic [RD_W-1:0] req_rd,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [31:0]     mem_req_addr,

    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,

    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [31:0]     wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [AW:0]   ptr_t;
    typedef logic [AW-1:0] idx_t;

    localparam logic [2:0] FncLb  = 3'b000;
    localparam logic [2:0] FncLh  = 3'b001;
    localparam logic [2:0] FncLw  = 3'b010;
    localparam logic [2:0] FncLbu = 3'b100;
    localparam logic [2:0] FncLhu = 3'b101;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ptr_t wr_ptr_q,  wr_ptr_d;
    ptr_t rsp_ptr_q, rsp_ptr_d;
    ptr_t rd_ptr_q,  rd_ptr_d;

    logic [DEPTH-1:0] dvalid_q, dvalid_d;

    // Entry payload; never reset, qualified by the pointers and dvalid.
    logic [2:0]      fnc_q  [DEPTH];
    logic [2:0]      fnc_d  [DEPTH];
    logic [1:0]      off_q  [DEPTH];
    logic [1:0]      off_d  [DEPTH];
    logic [RD_W-1:0] rd_q   [DEPTH];
    logic [RD_W-1:0] rd_d   [DEPTH];
    logic            err_q  [DEPTH];
    logic            err_d  [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];

    // ------------------------------------------------------------------
    // Queue status
    // ------------------------------------------------------------------
    idx_t wr_idx;
    idx_t rsp_idx;
    idx_t rd_idx;
    logic full;
    logic rsp_pending;
    logic head_valid;
    logic accept;
    logic rsp_take;
    logic pop;

    always_comb begin
        wr_idx  = wr_ptr_q[AW-1:0];
        rsp_idx = rsp_ptr_q[AW-1:0];
        rd_idx  = rd_ptr_q[AW-1:0];

        full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

        // Entries between rsp_ptr and wr_ptr have been issued but not answered.
        rsp_pending = (rsp_ptr_q != wr_ptr_q);

        // dvalid is only ever set on answered, not-yet-popped entries.
        head_valid = dvalid_q[rd_idx];
    end

    // ------------------------------------------------------------------
    // Request path: combinational pass-through to memory. Fullness comes
    // from registered state only, so a same-cycle pop never frees a slot
    // for a same-cycle request.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_valid = req_valid && !full;
        req_ready     = !full && mem_req_ready;
        mem_req_addr  = {req_addr[31:2], 2'b00};
        accept        = req_valid && req_ready;
        rsp_take      = mem_rsp_valid && rsp_pending;
        pop           = head_valid && wb_ready;
    end

    // Misalignment and illegal funct3 are both reported as an error load.
    logic req_err;

    always_comb begin
        unique case (req_fnc)
            FncLb, FncLbu: req_err = 1'b0;
            FncLh, FncLhu: req_err = (req_addr[1:0] == 2'b11);
            FncLw:         req_err = (req_addr[1:0] != 2'b00);
            default:       req_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rsp_ptr_d = rsp_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dvalid_d  = dvalid_q;
        fnc_d     = fnc_q;
        off_d     = off_q;
        rd_d      = rd_q;
        err_d     = err_q;
        data_d    = data_q;

        // The three updates below touch distinct slots: accept needs !full,
        // the response slot is unanswered (so it is not the head being
        // popped), and the response slot is never the slot being allocated.
        if (accept) begin
            fnc_d[wr_idx]    = req_fnc;
            off_d[wr_idx]    = req_addr[1:0];
            rd_d[wr_idx]     = req_rd;
            err_d[wr_idx]    = req_err;
            dvalid_d[wr_idx] = 1'b0;
            wr_ptr_d         = wr_ptr_q + ptr_t'(1);
        end

        if (rsp_take) begin
            data_d[rsp_idx]   = mem_rsp_data;
            dvalid_d[rsp_idx] = 1'b1;
            rsp_ptr_d         = rsp_ptr_q + ptr_t'(1);
        end

        if (pop) begin
            dvalid_d[rd_idx] = 1'b0;
            rd_ptr_d         = rd_ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rsp_ptr_q <= '0;
            rd_ptr_q  <= '0;
            dvalid_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rsp_ptr_q <= rsp_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dvalid_q  <= dvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        fnc_q  <= fnc_d;
        off_q  <= off_d;
        rd_q   <= rd_d;
        err_q  <= err_d;
        data_q <= data_d;
    end

    // ------------------------------------------------------------------
    // Writeback formatting, from stored head fields only
    // ------------------------------------------------------------------
    logic [31:0] head_shift;
    logic [31:0] head_fmt;

    always_comb begin
        // Bring the addressed byte/halfword down to bit 0.
        head_shift = data_q[rd_idx] >> {off_q[rd_idx], 3'b000};

        unique case (fnc_q[rd_idx])
            FncLb:   head_fmt = {{24{head_shift[7]}}, head_shift[7:0]};
            FncLbu:  head_fmt = {24'h000000, head_shift[7:0]};
            FncLh:   head_fmt = {{16{head_shift[15]}}, head_shift[15:0]};
            FncLhu:  head_fmt = {16'h0000, head_shift[15:0]};
            FncLw:   head_fmt = head_shift;
            default: head_fmt = 32'h0;
        endcase

        if (err_q[rd_idx]) begin
            head_fmt = 32'h0;
        end
    end

    always_comb begin
        wb_valid = head_valid;
        wb_data  = head_valid ? head_fmt : 32'h0;
        wb_rd    = head_valid ? rd_q[rd_idx] : '0;
        wb_err   = head_valid && err_q[rd_idx];
    end

endmodule

// File: tb/tb_mem_rd_return.sv
module tb_mem_rd_return;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RD_W  = 5;
    localparam int          LAT   = 2;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_fnc;
    logic [31:0]     req_addr;
    logic [RD_W-1:0] req_rd;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [31:0]     mem_req_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;
    logic            wb_valid;
    logic            wb_ready;
    logic [31:0]     wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_err;

    mem_rd_return #(
        .DEPTH(DEPTH),
        .RD_W (RD_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_fnc      (req_fnc),
        .req_addr     (req_addr),
        .req_rd       (req_rd),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RD_W-1:0] rd;
        logic [31:0]     data;
        logic            err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          iss;
    } pend_t;

    exp_t  sb_q[$];
    pend_t pend_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int occ     = 0;
    int n_resp_done = 0;
    int n_popped    = 0;
    int last_tries  = 0;

    logic        rsp_en    = 1'b0;
    logic        stray_en  = 1'b0;
    logic        rand_wb   = 1'b0;
    logic        accepted  = 1'b0;
    logic [31:0] cur_exp_data = 32'h0;
    logic        cur_exp_err  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: one word fixed for the extraction cases, others derived from address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h800) return 32'h80F1_7F02;
        return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
    endfunction

    function automatic void model(input logic [2:0] f, input logic [31:0] a,
                                  output logic [31:0] d, output logic e);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mem_word(a);
        case (a[1:0])
            2'd0:    begin b = w[7:0];   h = w[15:0];  end
            2'd1:    begin b = w[15:8];  h = w[23:8];  end
            2'd2:    begin b = w[23:16]; h = w[31:16]; end
            default: begin b = w[31:24]; h = 16'h0;    end
        endcase
        case (f)
            3'b000:  begin e = 1'b0; d = {{24{b[7]}}, b}; end
            3'b100:  begin e = 1'b0; d = {24'h0, b}; end
            3'b001:  begin e = (a[1:0] == 2'd3); d = {{16{h[15]}}, h}; end
            3'b101:  begin e = (a[1:0] == 2'd3); d = {16'h0, h}; end
            3'b010:  begin e = (a[1:0] != 2'd0); d = w; end
            default: begin e = 1'b1; d = 32'h0; end
        endcase
        if (e) d = 32'h0;
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        logic acc, pop, rsp, exp_rdy, exp_wbv;
        exp_t  e;
        pend_t p;
        if (rand_wb) wb_ready = 1'($urandom_range(0, 1));
        rsp = rsp_en && (pend_q.size() > 0) && (pend_q[0].iss + LAT <= cyc + 1);
        if (rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_q[0].addr);
        end else if (stray_en && pend_q.size() == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        exp_rdy = (occ < DEPTH) && mem_req_ready;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("mem_req_valid", mem_req_valid, req_valid && (occ < DEPTH));
        if (req_valid) check_eq("mem_req_addr", mem_req_addr, {req_addr[31:2], 2'b00});
        acc = req_valid && exp_rdy;
        if (acc) begin
            e.rd = req_rd; e.data = cur_exp_data; e.err = cur_exp_err;
            sb_q.push_back(e);
            p.addr = req_addr; p.iss = cyc + 1;
            pend_q.push_back(p);
        end
        exp_wbv = (n_resp_done > n_popped);
        check_eq("wb_valid", wb_valid, exp_wbv);
        if (wb_valid && sb_q.size() > 0) begin
            check_eq("wb_rd", wb_rd, sb_q[0].rd);
            check_eq("wb_data", wb_data, sb_q[0].data);
            check_eq("wb_err", wb_err, sb_q[0].err);
        end else if (!wb_valid) begin
            check_eq("wb_idle_zero", {wb_data[31:1], wb_data[0] | wb_err | (|wb_rd)}, 32'h0);
        end
        pop = wb_valid && wb_ready && (sb_q.size() > 0);
        @(posedge clk);
        cyc++;
        occ = occ + (acc ? 1 : 0) - (pop ? 1 : 0);
        if (rsp) begin
            void'(pend_q.pop_front());
            n_resp_done++;
        end
        if (pop) begin
            void'(sb_q.pop_front());
            n_popped++;
        end
        accepted = acc;
        @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] f, input logic [31:0] a, input logic [RD_W-1:0] rd,
                           input logic [31:0] xd, input logic xe);
        req_valid = 1'b1; req_fnc = f; req_addr = a; req_rd = rd;
        cur_exp_data = xd; cur_exp_err = xe;
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [RD_W-1:0] rd,
                        input logic [31:0] xd, input logic xe);
        int tries = 0;
        set_req(f, a, rd, xd, xe);
        accepted = 1'b0;
        while (!accepted && tries < 100) begin
            cycle();
            tries++;
        end
        check_eq("send_accepted", 32'(accepted), 32'd1);
        last_tries = tries;
        req_valid = 1'b0;
    endtask

    task automatic send_auto(input logic [2:0] f, input logic [31:0] a, input logic [RD_W-1:0] rd);
        logic [31:0] d;
        logic        e;
        model(f, a, d, e);
        send(f, a, rd, d, e);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(output int n);
        n = 0;
        req_valid = 1'b0; rand_wb = 1'b0; wb_ready = 1'b1; rsp_en = 1'b1;
        while (sb_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; req_valid = 1'b1; req_fnc = 3'b010; req_addr = 32'h40;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check_eq("rst_wb_valid", wb_valid, 0);
            check_eq("rst_req_ready", req_ready, 1);
            check_eq("rst_mem_req_valid", mem_req_valid, 1);
            check_eq("rst_wb_data", wb_data, 0);
            check_eq("rst_wb_rd", wb_rd, 0);
            check_eq("rst_wb_err", wb_err, 0);
        end
        rst_n = 1'b1; req_valid = 1'b0; mem_rsp_valid = 1'b0;
        sb_q.delete(); pend_q.delete();
        occ = 0; n_resp_done = 0; n_popped = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        logic [2:0] rf;
        req_valid = 0; req_fnc = 0; req_addr = 0; req_rd = 0;
        mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = 0; wb_ready = 0;

        // Reset with responses and a request pending at the inputs.
        do_reset(3);

        // Fill to DEPTH without responses, then further requests are refused.
        rsp_en = 0; wb_ready = 0;
        for (int i = 0; i < DEPTH; i++) send_auto(3'b010, 32'h100 + 32'(4 * i), 5'(i + 1));
        set_req(3'b010, 32'h200, 5'd9, 32'h0, 1'b0);
        cycle();
        cycle();
        check_eq("full_no_accept", 32'(accepted), 32'd0);
        req_valid = 0;
        drain(n);

        // Reset mid-operation discards outstanding loads.
        rsp_en = 0; wb_ready = 0;
        send_auto(3'b000, 32'h300, 5'd3);
        send_auto(3'b000, 32'h305, 5'd4);
        do_reset(2);
        rsp_en = 1; wb_ready = 1;
        idle(4);

        // Extraction from word 0x80F1_7F02.
        send(3'b000, 32'h2001, 5'd1, 32'h0000_007F, 1'b0);
        send(3'b000, 32'h2003, 5'd2, 32'hFFFF_FF80, 1'b0);
        send(3'b100, 32'h2003, 5'd3, 32'h0000_0080, 1'b0);
        send(3'b001, 32'h2002, 5'd4, 32'hFFFF_80F1, 1'b0);
        send(3'b101, 32'h2001, 5'd5, 32'h0000_F17F, 1'b0);
        send(3'b010, 32'h2000, 5'd6, 32'h80F1_7F02, 1'b0);
        drain(n);

        // Errors, interleaved with good neighbours.
        send_auto(3'b010, 32'h1000, 5'd7);
        send(3'b010, 32'h1002, 5'd8, 32'h0, 1'b1);
        send(3'b001, 32'h1003, 5'd9, 32'h0, 1'b1);
        send(3'b011, 32'h1000, 5'd10, 32'h0, 1'b1);
        send_auto(3'b010, 32'h1004, 5'd11);
        drain(n);

        // Ordering under writeback backpressure.
        rsp_en = 1; wb_ready = 0;
        for (int i = 0; i < 4; i++) send_auto(3'b010, 32'h400 + 32'(4 * i), 5'(i + 1));
        idle(10);
        drain(n);
        check_eq("bp_drain_cycles", 32'(n), 32'd4);

        // At full: pop + response + request in one cycle; request waits a cycle.
        rsp_en = 0; wb_ready = 0;
        for (int i = 0; i < DEPTH; i++) send_auto(3'b100, 32'h500 + 32'(i), 5'(i + 12));
        rsp_en = 1; wb_ready = 1;
        send_auto(3'b001, 32'h600, 5'd20);
        check_eq("full_accept_tries", 32'(last_tries), 32'd3);
        drain(n);

        // Pointer wrap over 3*DEPTH loads with random writeback stalls.
        rand_wb = 1; rsp_en = 1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            rf = 3'($urandom_range(0, 7));
            send_auto(rf, $urandom & 32'h0000_FFFF, 5'($urandom_range(0, 31)));
        end
        drain(n);

        // Responses with nothing outstanding are ignored.
        stray_en = 1;
        idle(3);
        stray_en = 0;
        idle(1);

        // Sustained throughput of one load per cycle.
        c0 = cyc;
        rsp_en = 1; wb_ready = 1;
        for (int i = 0; i < 8; i++) send_auto(3'b010, 32'h800 + 32'(4 * i), 5'(i));
        check_eq("throughput_cycles", 32'(cyc - c0), 32'd8);
        drain(n);

        // Memory not ready: nothing allocated, mem_req_valid still follows req_valid.
        mem_req_ready = 0;
        set_req(3'b010, 32'h900, 5'd1, 32'h0, 1'b0);
        cycle(); cycle(); cycle();
        check_eq("memstall_no_accept", 32'(accepted), 32'd0);
        req_valid = 0;
        cycle();
        mem_req_ready = 1;
        send_auto(3'b010, 32'h904, 5'd2);
        drain(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
